// File: rtl/clock_divider_bank.sv
// Multi-channel programmable divider: 50 % duty square waves of period 2*HALF plus a rising tick.
// Optional macro CLKDIV_SHADOW_EN defers divisor writes to the end of the current full period.
module clock_divider_bank #(
  parameter int CHANNELS     = 4,
  parameter int WIDTH        = 25,
  parameter int DEFAULT_HALF = 25
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] EN,
  input  logic                SYNC,
  input  logic                WR_EN,
  input  logic [3:0]          WR_CH,
  input  logic [WIDTH-1:0]    WR_HALF,
  output logic                WR_ACK,
  output logic                WR_ERR,
  output logic [CHANNELS-1:0] CLK_OUT,
  output logic [CHANNELS-1:0] TICK
);

  localparam logic [WIDTH-1:0] HalfRst = WIDTH'(DEFAULT_HALF);

  logic wr_valid;
  assign wr_valid = WR_EN && (32'(WR_CH) < 32'(CHANNELS));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      WR_ACK <= 1'b0;
      WR_ERR <= 1'b0;
    end else begin
      WR_ACK <= wr_valid;
      WR_ERR <= WR_EN && !wr_valid;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] half_q;
    logic             out_q;
    logic             tick_q;
    logic             wr_hit;
    logic             run;
    logic             wrap;
    logic             apply;
    logic             restart;
    logic [WIDTH-1:0] new_half;

    assign wr_hit = wr_valid && (WR_CH == 4'(g));
    assign run    = EN[g] && (half_q != '0);
    // >= rather than == so a divisor lowered below CNT wraps next edge instead of rolling over
    assign wrap   = cnt_q >= (half_q - WIDTH'(1));

`ifdef CLKDIV_SHADOW_EN
    logic             pend_q;
    logic [WIDTH-1:0] pend_val_q;
    logic             eff_pend;

    assign eff_pend = wr_hit || pend_q;
    assign new_half = wr_hit ? WR_HALF : pend_val_q;
    // Apply at the 1->0 wrap (end of a full period), or at once if the channel is not counting
    assign apply    = eff_pend && (SYNC || !run || (wrap && out_q));
    assign restart  = 1'b0;

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        pend_q     <= 1'b0;
        pend_val_q <= '0;
      end else if (apply) begin
        pend_q     <= 1'b0;
      end else if (wr_hit) begin
        pend_q     <= 1'b1;
        pend_val_q <= WR_HALF;
      end
    end
`else
    assign new_half = WR_HALF;
    assign apply    = wr_hit;
    // Immediate write restarts the current half-period at its new length
    assign restart  = wr_hit;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        cnt_q  <= '0;
        half_q <= HalfRst;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        if (apply) begin
          half_q <= new_half;
        end
        if (SYNC || !run) begin
          cnt_q  <= '0;
          out_q  <= 1'b0;
          tick_q <= 1'b0;
        end else if (restart) begin
          cnt_q  <= '0;
          tick_q <= 1'b0;
        end else if (wrap) begin
          cnt_q  <= '0;
          out_q  <= ~out_q;
          tick_q <= ~out_q;
        end else begin
          cnt_q  <= cnt_q + WIDTH'(1);
          tick_q <= 1'b0;
        end
      end
    end

    assign CLK_OUT[g] = out_q;
    assign TICK[g]    = tick_q;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: table-driven writes plus a scoreboard of expected
// CLK_OUT/TICK per cycle derived from the period formula.
module tb_clock_divider_bank;

  localparam int CH = 4;
  localparam int W  = 25;

  typedef int half_arr_t [CH];

  typedef struct {
    logic [CH-1:0] mask;
    logic [CH-1:0] out;
    logic [CH-1:0] tick;
  } exp_t;

  typedef struct {
    logic [3:0]   ch;
    logic [W-1:0] half;
    logic         ack;
    logic         err;
  } wr_vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] en = '0;
  logic          sync = 1'b0;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_ch = '0;
  logic [W-1:0]  wr_half = '0;
  logic          wr_ack;
  logic          wr_err;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;

  exp_t    sbq[$];
  wr_vec_t tbl [5];
  int      checks = 0;
  int      errors = 0;

  clock_divider_bank #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_HALF(25)) dut (
    .CLK(clk), .RESET(rst), .EN(en), .SYNC(sync), .WR_EN(wr_en), .WR_CH(wr_ch),
    .WR_HALF(wr_half), .WR_ACK(wr_ack), .WR_ERR(wr_err), .CLK_OUT(clk_out), .TICK(tick)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // k = edges since the restart edge (sync edge is k=0, first edge after reset release is k=1)
  function automatic logic exp_o(input int h, input int k);
    if (h == 0 || k <= 0) return 1'b0;
    return ((k / h) % 2) == 1;
  endfunction

  function automatic logic exp_t_(input int h, input int k);
    if (h == 0 || k <= 0) return 1'b0;
    return (k % (2 * h)) == h;
  endfunction

  task automatic push_formula(input half_arr_t hv, input int k, input logic [CH-1:0] mask);
    exp_t e;
    e.mask = mask;
    for (int c = 0; c < CH; c++) begin
      e.out[c]  = exp_o(hv[c], k);
      e.tick[c] = exp_t_(hv[c], k);
    end
    sbq.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic step_sb(input string tag);
    exp_t e;
    idle();
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty at %0t", tag, $time);
    end else begin
      e = sbq.pop_front();
      check_val({tag, "_clk_out"}, 32'(clk_out & e.mask), 32'(e.out & e.mask));
      check_val({tag, "_tick"}, 32'(tick & e.mask), 32'(e.tick & e.mask));
    end
  endtask

  task automatic write(input logic [3:0] ch, input logic [W-1:0] half);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_half = half;
  endtask

  initial begin
    half_arr_t hv;
    exp_t      e;
    int        j;

    tbl[0] = '{ch: 4'd2,  half: 25'd1, ack: 1'b1, err: 1'b0};
    tbl[1] = '{ch: 4'd3,  half: 25'd0, ack: 1'b1, err: 1'b0};
    tbl[2] = '{ch: 4'd7,  half: 25'd9, ack: 1'b0, err: 1'b1};
    tbl[3] = '{ch: 4'd4,  half: 25'd9, ack: 1'b0, err: 1'b1};
    tbl[4] = '{ch: 4'd15, half: 25'd3, ack: 1'b0, err: 1'b1};

    // Reset state, then free-running at the default half-period
    en = '1;
    idle();
    idle();
    check_val("rst_clk_out", 32'(clk_out), 0);
    check_val("rst_tick", 32'(tick), 0);
    check_val("rst_ack", 32'(wr_ack), 0);
    check_val("rst_err", 32'(wr_err), 0);
    rst = 1'b0;
    hv = '{25, 25, 25, 25};
    for (int k = 1; k <= 110; k++) begin
      push_formula(hv, k, '1);
      step_sb("default");
    end

    // Back-to-back writes from the table; ack/err for each visible one cycle later
    for (int i = 0; i < 5; i++) begin
      write(tbl[i].ch, tbl[i].half);
      idle();
      check_val($sformatf("wr%0d_ack", i), 32'(wr_ack), 32'(tbl[i].ack));
      check_val($sformatf("wr%0d_err", i), 32'(wr_err), 32'(tbl[i].err));
    end
    wr_en = 1'b0;
    idle();
    check_val("wr_ack_clear", 32'(wr_ack), 0);
    check_val("wr_err_clear", 32'(wr_err), 0);

    // Channel 3 must be stopped and channel 7/15 writes must not alias onto real channels
    sync = 1'b1;
    hv = '{25, 25, 1, 0};
    push_formula(hv, 0, '1);
    step_sb("sync_a");
    sync = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      push_formula(hv, k, '1);
      step_sb("half1_half0");
    end

    // Program 3/5/7, run, then phase-align with SYNC
    write(4'd0, 25'd3);
    idle();
    write(4'd1, 25'd5);
    idle();
    write(4'd2, 25'd7);
    idle();
    wr_en = 1'b0;
    for (int i = 0; i < 100; i++) idle();
    sync = 1'b1;
    hv = '{3, 5, 7, 0};
    push_formula(hv, 0, '1);
    step_sb("sync_b");
    sync = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      push_formula(hv, k, '1);
      step_sb("phase");
    end

    // Write together with SYNC, then lower the divisor in the middle of the high phase
    write(4'd0, 25'd10);
    sync = 1'b1;
    hv = '{10, 5, 7, 0};
    push_formula(hv, 0, 4'b0001);
    step_sb("wr_sync");
    sync  = 1'b0;
    wr_en = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      push_formula(hv, k, 4'b0001);
      step_sb("h10");
    end
    write(4'd0, 25'd4);
    push_formula(hv, 14, 4'b0001);
    step_sb("h10_wr");
    wr_en = 1'b0;
    for (int k = 15; k <= 45; k++) begin
      e.mask = 4'b0001;
      e.out  = '0;
      e.tick = '0;
`ifdef CLKDIV_SHADOW_EN
      if (k < 20) begin
        e.out[0]  = exp_o(10, k);
        e.tick[0] = exp_t_(10, k);
      end else begin
        e.out[0]  = exp_o(4, k - 20);
        e.tick[0] = exp_t_(4, k - 20);
      end
`else
      j = k - 14;
      e.out[0]  = ((j / 4) % 2) == 0;
      e.tick[0] = (j > 0) && ((j % 8) == 0);
`endif
      sbq.push_back(e);
      step_sb("h4");
    end

    // Asynchronous reset mid-period while WR_ACK is high
    write(4'd1, 25'd2);
    idle();
    wr_en = 1'b0;
    check_val("pre_rst_ack", 32'(wr_ack), 1);
    #2 rst = 1'b1;
    #1;
    check_val("async_clk_out", 32'(clk_out), 0);
    check_val("async_tick", 32'(tick), 0);
    check_val("async_ack", 32'(wr_ack), 0);
    check_val("async_err", 32'(wr_err), 0);
    idle();
    rst = 1'b0;
    hv = '{25, 25, 25, 25};
    for (int k = 1; k <= 60; k++) begin
      push_formula(hv, k, '1);
      step_sb("post_rst");
    end

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
